// File: rtl/dat_init.sv
// dat_init: loads and checks the external DAT (MMU task-map) SRAM.
// Walks a range of DAT entries {task, slot} and writes the identity map or
// a fill word, or read-verifies the identity map. While busy it owns the
// SRAM address, data and write strobes; the MMU muxes these in on busy.
module dat_init #(
    parameter int TASK_WIDTH = 12,
    parameter bit AUTO_INIT  = 1'b1
) (
    input  logic                  e,
    input  logic                  _reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [TASK_WIDTH-1:0] first_task,
    input  logic [TASK_WIDTH-1:0] last_task,
    input  logic [15:0]           fill_data,
    input  logic [15:0]           data_dat_in,
    output logic [TASK_WIDTH+2:0] address_dat,
    output logic [15:0]           data_dat_out,
    output logic                  data_dat_oe,
    output logic                  _we_dat_l,
    output logic                  _we_dat_h,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [TASK_WIDTH+2:0] error_addr,
    output logic [7:0]            error_count
);

    localparam int AW = TASK_WIDTH + 3;

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   counter;
    logic [AW-1:0]   counter_inc;
    logic [AW-1:0]   end_addr;
    logic [15:0]     fill_word;
    logic            fill_mode;
    logic            auto_pend;
    logic            at_end;
    logic            auto_go;
    logic            cmd_go;
    logic            range_ok;
    logic            mismatch;

    // Identity map word: low three bits are the slot number.
    function automatic logic [15:0] identity_word(input logic [AW-1:0] a);
        return {13'd0, a[2:0]};
    endfunction

    // Saturating 8-bit increment for the mismatch counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    assign counter_inc = counter + AW'(1);
    assign at_end      = (counter == end_addr);
    assign range_ok    = (first_task <= last_task);
    // Auto-init wins over a command arriving on the same first edge.
    assign auto_go     = (state == IDLE) && auto_pend;
    assign cmd_go      = (state == IDLE) && !auto_pend && start;
    assign mismatch    = (data_dat_in != identity_word(counter));
    assign address_dat = counter;

    // State register.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (auto_go) begin
                    state_nxt = WRITE;
                end else if (start) begin
                    if (mode == 2'd3 || !range_ok) state_nxt = DONE;
                    else if (mode == 2'd2)         state_nxt = VERIFY;
                    else                           state_nxt = WRITE;
                end
            end
            WRITE:   if (at_end) state_nxt = DONE;
            VERIFY:  if (at_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; strobes are a high-phase pulse of e so they release as soon as reset forces IDLE.
    always_comb begin
        busy        = (state == WRITE) || (state == VERIFY);
        done        = (state == DONE);
        data_dat_oe = (state == WRITE);
        _we_dat_l   = !((state == WRITE) && e);
        _we_dat_h   = !((state == WRITE) && e);
    end

    // Address counter, latched mode and the once-per-release auto-init flag; the counter holds at the end address so it never wraps.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) begin
            counter   <= '0;
            fill_mode <= 1'b0;
            auto_pend <= AUTO_INIT;
        end else if (auto_go) begin
            counter   <= '0;
            fill_mode <= 1'b0;
            auto_pend <= 1'b0;
        end else if (cmd_go) begin
            counter   <= {first_task, 3'b000};
            fill_mode <= (mode == 2'd1);
        end else if (busy && !at_end) begin
            counter   <= counter_inc;
        end
    end

    // Range end, fill word and registered write data for the entry being addressed.
    always_ff @(posedge e) begin
        if (auto_go) begin
            end_addr     <= '1;
            data_dat_out <= identity_word('0);
        end else if (cmd_go) begin
            end_addr     <= {last_task, 3'b111};
            fill_word    <= fill_data;
            data_dat_out <= (mode == 2'd1) ? fill_data : identity_word({first_task, 3'b000});
        end else if (state == WRITE && !at_end) begin
            data_dat_out <= fill_mode ? fill_word : identity_word(counter_inc);
        end
    end

    // Verify bookkeeping: sticky error flag, first failing address and saturating count, cleared by each start.
    always_ff @(posedge e or negedge _reset) begin
        if (!_reset) begin
            error       <= 1'b0;
            error_addr  <= '0;
            error_count <= '0;
        end else if (cmd_go) begin
            error       <= 1'b0;
            error_addr  <= '0;
            error_count <= '0;
        end else if (state == VERIFY && mismatch) begin
            error_count <= sat_inc8(error_count);
            if (!error) begin
                error      <= 1'b1;
                error_addr <= counter;
            end
        end
    end

endmodule

// File: doc/dat_init.md
Name: dat_init

Overview:
- Sequencer that loads and checks the external DAT (MMU task-map) SRAM.
- Sits upstream of the MMU datapath. The MMU reads the DAT SRAM for every translated access, but the SRAM powers up with random contents.
- After reset, or on command, it walks a range of tasks and writes an identity map or a fill word, or read-verifies the identity map.
- While busy it owns the DAT SRAM address, data and write strobes; the MMU muxes these in on `busy`.

Parameters:
- TASK_WIDTH, 12, task number width; DAT index = {task, slot[2:0]}, so address width is TASK_WIDTH+3.
- AUTO_INIT, 1, when 1 an identity write of all tasks starts on the first clock after reset release.

Ports:
- e  input  1  system clock (CPU E clock), rising-edge registers.
- _reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe, sampled on rising e.
- mode  input  2  0=identity write, 1=fill write, 2=verify identity, 3=reserved (treated as no-op).
- first_task  input  TASK_WIDTH  first task of range, inclusive.
- last_task  input  TASK_WIDTH  last task of range, inclusive.
- fill_data  input  16  word written in fill mode.
- data_dat_in  input  16  DAT SRAM read data (asynchronous SRAM, valid within the addressed cycle).
- address_dat  output  TASK_WIDTH+3  DAT SRAM address while busy.
- data_dat_out  output  16  write data.
- data_dat_oe  output  1  drive data_dat_out onto the DAT bus.
- _we_dat_l  output  1  active-low low-byte write strobe.
- _we_dat_h  output  1  active-low high-byte write strobe.
- busy  output  1  engine owns the DAT SRAM.
- done  output  1  one-cycle pulse at end of operation.
- error  output  1  verify mismatch seen (sticky until next start).
- error_addr  output  TASK_WIDTH+3  address of first mismatch.
- error_count  output  8  mismatch count, saturating at 0xFF.

Behaviour:
- Reset (async, while _reset=0):
  - state=IDLE; busy=0, done=0, data_dat_oe=0, _we_dat_l=_we_dat_h=1.
  - error=0, error_addr=0, error_count=0, address_dat=0.
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - First edge after reset release with AUTO_INIT=1: load counter=0, end=all ones, mode identity, go to WRITE. This happens once per reset release.
  - start=1: clear error, error_addr and error_count, then:
    - mode 0/1 -> WRITE.
    - mode 2 -> VERIFY.
    - mode 3, or first_task>last_task -> DONE directly; no strobe is issued.
  - Counter loads {first_task,3'b000}; end loads {last_task,3'b111}.
- start while busy or in DONE is ignored; inputs are latched only at start.
- WRITE:
  - One entry per e cycle. Registered address_dat=counter, data_dat_out=pattern, data_dat_oe=1.
  - Strobes are combinational: _we_dat_l = _we_dat_h = !(state==WRITE & e), a high-phase pulse. Both bytes are always written.
  - Identity pattern: {8'h00, 5'b0, counter[2:0]}. Fill pattern: fill_data.
  - counter==end: go to DONE without incrementing, so no wrap at the all-ones address.
- VERIFY:
  - No strobes; data_dat_oe=0.
  - data_dat_in is sampled on the rising edge that ends each addressed cycle and compared with the identity pattern for that address.
  - On mismatch: error_count += 1, saturating. If error was 0, set error=1 and error_addr=address.
  - Verify continues to the end of the range; it does not stop on error.
  - counter==end: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, next state IDLE.
- busy=1 in WRITE and VERIFY only.
- Reset asserted mid-operation: strobes release immediately, all outputs return to reset values, and the range is abandoned. With AUTO_INIT=1 a full identity write restarts after release.
- Latency:
  - start edge -> first address on the next edge; busy rises on that same edge.
  - An N-entry operation holds busy for N cycles, followed by one done cycle.

Test Plan:
1. TASK_WIDTH=2, AUTO_INIT=1, release reset -> busy=1 on the first edge and 32 writes follow. Check addr 0x00 data 0x0000, addr 0x05 data 0x0005, addr 0x09 data 0x0001, addr 0x1F data 0x0007. Then one done pulse, busy=0.
2. Fill mode, first_task=1, last_task=2, fill_data=0xA55A -> exactly 16 write strobes at addresses 0x08–0x17, all with data 0xA55A. No strobe at 0x07 or 0x18.
3. Verify mode over all tasks, with the SRAM model returning 0x00FF at 0x0D and 0x1A -> error=1, error_addr=0x0D, error_count=2, done pulses after 32 cycles.
4. first_task=3, last_task=1 with start -> done pulses on the next cycle, busy stays 0, no strobe. A start pulse issued during a running fill is ignored and the range is unchanged.
5. Assert _reset mid-fill at address 0x0B -> _we_dat_l/_we_dat_h go high and data_dat_oe goes 0 without waiting for an edge. After release the AUTO_INIT identity write restarts at 0x00.
6. TASK_WIDTH=12, identity write with last_task=0xFFF -> the final write is at 0x7FFF with data 0x0007, the counter does not wrap to 0, and done follows.
